// File: rtl/fetch_unit_if.sv
// Bus bundle for fetch_unit: imem request/response, redirect from execute,
// and the instruction hand-off to decode. master = fetch side, slave = environment.
interface fetch_unit_if #(
    parameter int unsigned DATA_W = 32
);
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [DATA_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [DATA_W-1:0] imem_rsp_data;
    logic              redirect_valid;
    logic [DATA_W-1:0] redirect_target;
    logic              if_valid;
    logic              if_ready;
    logic [DATA_W-1:0] if_instr;
    logic [DATA_W-1:0] if_pc;
    logic [DATA_W-1:0] if_pc_plus4;
    logic              fetch_misalign;

    modport master (
        output imem_req_valid, imem_req_addr,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data,
        input  redirect_valid, redirect_target,
        output if_valid, if_instr, if_pc, if_pc_plus4,
        input  if_ready,
        output fetch_misalign
    );

    modport slave (
        input  imem_req_valid, imem_req_addr,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data,
        output redirect_valid, redirect_target,
        input  if_valid, if_instr, if_pc, if_pc_plus4,
        output if_ready,
        input  fetch_misalign
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in flight,
// hands instructions to decode. Optional sticky misalign flag: FETCH_ALIGN_CHECK_EN.
module fetch_unit #(
    parameter int unsigned       DATA_W   = 32,
    parameter logic [DATA_W-1:0] RESET_PC = '0
) (
    input logic         clk,
    input logic         reset,
    fetch_unit_if.master bus
);

    typedef enum logic [1:0] {
        S_REQ,
        S_WAIT,
        S_HOLD,
        S_DRAIN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_pc;
    logic [DATA_W-1:0] w_pc_nxt;
    logic [DATA_W-1:0] w_pc_plus4;
    logic [DATA_W-1:0] w_redirect_pc;
    logic              r_if_valid;
    logic              w_if_valid_nxt;
    logic [DATA_W-1:0] r_if_instr;
    logic [DATA_W-1:0] r_if_pc;
    logic [DATA_W-1:0] r_if_pc_plus4;
    logic              w_capture;
    logic              w_req_valid;
    logic              w_accept;
    logic              w_misalign;

    assign w_req_valid   = (r_state == S_REQ) & ~reset;
    assign w_accept      = w_req_valid & bus.imem_req_ready;
    assign w_pc_plus4    = r_pc + DATA_W'(4);
    assign w_redirect_pc = {bus.redirect_target[DATA_W-1:2], 2'b00};

    always_comb begin
        w_state_nxt    = r_state;
        w_pc_nxt       = r_pc;
        w_if_valid_nxt = r_if_valid;
        w_capture      = 1'b0;

        if (bus.redirect_valid) begin
            // Redirect wins; only the in-flight bookkeeping depends on state.
            w_pc_nxt       = w_redirect_pc;
            w_if_valid_nxt = 1'b0;
            case (r_state)
                S_REQ:   w_state_nxt = w_accept ? S_DRAIN : S_REQ;
                S_WAIT:  w_state_nxt = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
                S_HOLD:  w_state_nxt = S_REQ;
                S_DRAIN: w_state_nxt = bus.imem_rsp_valid ? S_REQ : S_DRAIN;
                default: w_state_nxt = S_REQ;
            endcase
        end else begin
            case (r_state)
                S_REQ: begin
                    if (w_accept) begin
                        w_state_nxt = S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (bus.imem_rsp_valid) begin
                        w_capture      = 1'b1;
                        w_if_valid_nxt = 1'b1;
                        w_state_nxt    = S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (r_if_valid && bus.if_ready) begin
                        w_if_valid_nxt = 1'b0;
                        w_pc_nxt       = w_pc_plus4;
                        w_state_nxt    = S_REQ;
                    end
                end
                S_DRAIN: begin
                    if (bus.imem_rsp_valid) begin
                        w_state_nxt = S_REQ;
                    end
                end
                default: w_state_nxt = S_REQ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= S_REQ;
            r_pc          <= RESET_PC;
            r_if_valid    <= 1'b0;
            r_if_instr    <= '0;
            r_if_pc       <= RESET_PC;
            r_if_pc_plus4 <= RESET_PC + DATA_W'(4);
        end else begin
            r_state    <= w_state_nxt;
            r_pc       <= w_pc_nxt;
            r_if_valid <= w_if_valid_nxt;
            if (w_capture) begin
                r_if_instr    <= bus.imem_rsp_data;
                r_if_pc       <= r_pc;
                r_if_pc_plus4 <= w_pc_plus4;
            end
        end
    end

`ifdef FETCH_ALIGN_CHECK_EN
    logic r_misalign;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_misalign <= 1'b0;
        end else if (bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00)) begin
            r_misalign <= 1'b1;
        end
    end

    assign w_misalign = r_misalign;
`else
    logic w_unused_target_lo;

    assign w_unused_target_lo = ^bus.redirect_target[1:0];
    assign w_misalign         = 1'b0;
`endif

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.if_valid       = r_if_valid;
    assign bus.if_instr       = r_if_instr;
    assign bus.if_pc          = r_if_pc;
    assign bus.if_pc_plus4    = r_if_pc_plus4;
    assign bus.fetch_misalign = w_misalign;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: inputs driven and outputs checked just after
// each falling edge, memory responses supplied by hand in the stimulus sequence.
module tb_fetch_unit;

    localparam logic [31:0] MAGIC = 32'hA5A5_0000;
`ifdef FETCH_ALIGN_CHECK_EN
    localparam logic [31:0] EXP_MIS = 32'd1;
`else
    localparam logic [31:0] EXP_MIS = 32'd0;
`endif

    logic clk = 1'b0;
    logic reset;
    int   n_cmp  = 0;
    int   n_fail = 0;

    fetch_unit_if #(.DATA_W(32)) bus ();

    fetch_unit #(.DATA_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.imem_req_ready  = 1'b0;
        bus.imem_rsp_valid  = 1'b0;
        bus.imem_rsp_data   = '0;
        bus.redirect_valid  = 1'b0;
        bus.redirect_target = '0;
        bus.if_ready        = 1'b0;
    endtask

    // Entry: just after a falling edge with the DUT in REQ at address a.
    // Zero-wait memory, decode stalls for `stall` HOLD cycles.
    task automatic fetch(input logic [31:0] a, input int unsigned stall);
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b1;
        bus.imem_rsp_valid = 1'b0;
        bus.if_ready       = 1'b1;
        #1;
        chk("req_valid_req", 32'(bus.imem_req_valid), 32'd1);
        chk("req_addr", bus.imem_req_addr, a);
        chk("if_valid_req", 32'(bus.if_valid), 32'd0);
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = a ^ MAGIC;
        #1;
        chk("req_valid_wait", 32'(bus.imem_req_valid), 32'd0);
        chk("if_valid_wait", 32'(bus.if_valid), 32'd0);
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        bus.if_ready       = (stall == 0);
        #1;
        for (int unsigned i = 0; i < stall; i++) begin
            chk("stall_valid", 32'(bus.if_valid), 32'd1);
            chk("stall_pc", bus.if_pc, a);
            chk("stall_instr", bus.if_instr, a ^ MAGIC);
            chk("stall_no_req", 32'(bus.imem_req_valid), 32'd0);
            @(negedge clk);
            bus.if_ready = (i + 1 == stall);
            #1;
        end
        chk("hold_valid", 32'(bus.if_valid), 32'd1);
        chk("hold_pc", bus.if_pc, a);
        chk("hold_instr", bus.if_instr, a ^ MAGIC);
        chk("hold_pc4", bus.if_pc_plus4, a + 32'd4);
        chk("hold_no_req", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
    endtask

    initial begin
        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
        chk("rst_if_instr", bus.if_instr, 32'h0);
        chk("rst_if_pc", bus.if_pc, 32'h0);
        chk("rst_if_pc4", bus.if_pc_plus4, 32'h4);
        chk("rst_misalign", 32'(bus.fetch_misalign), 32'd0);
        chk("rst_addr", bus.imem_req_addr, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Back-to-back zero-wait fetches: one every 3 cycles
        fetch(32'h0, 0);
        fetch(32'h4, 0);
        fetch(32'h8, 0);

        // Decode stalls 5 cycles in HOLD
        fetch(32'hC, 5);

        // Slow response, redirect in 2nd WAIT cycle -> DRAIN drops it
        bus.imem_req_ready = 1'b1;
        #1;
        chk("t3_addr", bus.imem_req_addr, 32'h10);
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        #1;
        chk("t3_wait1_noreq", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0100;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t3_drain_noreq", 32'(bus.imem_req_valid), 32'd0);
        chk("t3_drain_ifv", 32'(bus.if_valid), 32'd0);
        @(negedge clk);
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h10 ^ MAGIC;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        #1;
        chk("t3_dropped", 32'(bus.if_valid), 32'd0);
        chk("t3_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t3_new_addr", bus.imem_req_addr, 32'h100);
        fetch(32'h100, 0);

        // Redirect in REQ without accept, then redirect coinciding with accept
        bus.imem_req_ready  = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h20;
        #1;
        chk("t4_addr_before", bus.imem_req_addr, 32'h104);
        @(negedge clk);
        bus.redirect_target = 32'h40;
        bus.imem_req_ready  = 1'b1;
        #1;
        chk("t4_addr_20", bus.imem_req_addr, 32'h20);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h20 ^ MAGIC;
        #1;
        chk("t4_drain_noreq", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        #1;
        chk("t4_dropped", 32'(bus.if_valid), 32'd0);
        chk("t4_next_addr", bus.imem_req_addr, 32'h40);
        fetch(32'h40, 0);

        // PC wrap at top of address space
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'hFFFF_FFFC;
        bus.imem_req_ready  = 1'b0;
        @(negedge clk);
        fetch(32'hFFFF_FFFC, 0);
        fetch(32'h0, 0);

        // Redirect with response in same WAIT cycle, then redirect during HOLD handshake
        bus.imem_req_ready = 1'b1;
        #1;
        chk("t6_addr", bus.imem_req_addr, 32'h4);
        @(negedge clk);
        bus.imem_req_ready  = 1'b0;
        bus.imem_rsp_valid  = 1'b1;
        bus.imem_rsp_data   = 32'h4 ^ MAGIC;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h200;
        @(negedge clk);
        bus.imem_rsp_valid = 1'b0;
        bus.redirect_valid = 1'b0;
        #1;
        chk("t6_discard", 32'(bus.if_valid), 32'd0);
        chk("t6_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t6_addr_200", bus.imem_req_addr, 32'h200);
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = 32'h200 ^ MAGIC;
        @(negedge clk);
        bus.imem_rsp_valid  = 1'b0;
        bus.if_ready        = 1'b1;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h300;
        #1;
        chk("t6_hold_valid", 32'(bus.if_valid), 32'd1);
        chk("t6_hold_pc", bus.if_pc, 32'h200);
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        bus.if_ready       = 1'b0;
        #1;
        chk("t6_after_ifv", 32'(bus.if_valid), 32'd0);
        chk("t6_addr_300", bus.imem_req_addr, 32'h300);
        chk("t6_misalign0", 32'(bus.fetch_misalign), 32'd0);

        // Misaligned redirect target
        bus.imem_req_ready  = 1'b0;
        bus.redirect_valid  = 1'b1;
        bus.redirect_target = 32'h0000_0046;
        @(negedge clk);
        bus.redirect_valid = 1'b0;
        #1;
        chk("t7_addr_44", bus.imem_req_addr, 32'h44);
        chk("t7_misalign", 32'(bus.fetch_misalign), EXP_MIS);
        fetch(32'h44, 0);
        #1;
        chk("t7_misalign_sticky", 32'(bus.fetch_misalign), EXP_MIS);

        // Reset while a request is outstanding
        bus.imem_req_ready = 1'b1;
        @(negedge clk);
        bus.imem_req_ready = 1'b0;
        reset = 1'b1;
        #1;
        chk("t8_rst_noreq", 32'(bus.imem_req_valid), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("t8_req_valid", 32'(bus.imem_req_valid), 32'd1);
        chk("t8_addr", bus.imem_req_addr, 32'h0);
        chk("t8_if_valid", 32'(bus.if_valid), 32'd0);
        chk("t8_misalign", 32'(bus.fetch_misalign), 32'd0);
        chk("t8_if_pc", bus.if_pc, 32'h0);
        fetch(32'h0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
